// File: rtl/matrix_column_scanner.sv
// Time-multiplexes a latched DATA_WIDTH-bit image onto a column-scanned LED matrix,
// one column per DIVIDER-cycle slot, with a blanking gap at the start of each slot.
module matrix_column_scanner #(
  parameter int DATA_WIDTH    = 35,
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DIVIDER       = 50000,
  parameter int BLANK_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    display_data,
  output logic [COLUNE_SIZE-1:0]   row_out,
  output logic [TOTAL_COLUNES-1:0] colune_sel,
  output logic                     frame_done
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int COL_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(TOTAL_COLUNES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [COL_W-1:0]         col, col_nxt;
  logic [DATA_WIDTH-1:0]    frame_buf, buf_nxt;
  logic [COLUNE_SIZE-1:0]   row_nxt;
  logic [TOTAL_COLUNES-1:0] sel_nxt;
  logic                     done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      col        <= '0;
      frame_buf  <= '0;
      row_out    <= '0;
      colune_sel <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      col        <= col_nxt;
      frame_buf  <= buf_nxt;
      row_out    <= row_nxt;
      colune_sel <= sel_nxt;
      frame_done <= done_nxt;
    end
  end

  // Outputs follow (cnt, col) one cycle late; the image is only re-latched at the frame wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    buf_nxt   = frame_buf;
    row_nxt   = '0;
    sel_nxt   = '1;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          col_nxt   = '0;
          buf_nxt   = display_data;
        end
      end
      SCAN: begin
        if (cnt >= BLANK_END) begin
          row_nxt = frame_buf[COLUNE_SIZE*col +: COLUNE_SIZE];
          sel_nxt = ~(TOTAL_COLUNES'(1) << col);
        end
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          col_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_nxt = '0;
          if (col == COL_MAX) begin
            col_nxt  = '0;
            buf_nxt  = display_data;
            done_nxt = 1'b1;
          end else begin
            col_nxt = col + COL_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Randomized/directed bench for matrix_column_scanner against a positional frame model.
module tb_matrix_column_scanner;

  localparam int DW  = 35;
  localparam int CS  = 7;
  localparam int TC  = 5;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRAME = DIV * TC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] display_data = '0;
  logic [CS-1:0] row_out;
  logic [TC-1:0] colune_sel;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  // Model: scan-edge index since enable, plus the image latched for the current frame.
  bit            m_active = 1'b0;
  int            m_n = 0;
  logic [DW-1:0] m_img = '0;
  logic [CS-1:0] exp_row;
  logic [TC-1:0] exp_sel;
  logic          exp_done;
  logic [DW-1:0] cur_data;

  matrix_column_scanner #(
    .DATA_WIDTH(DW), .COLUNE_SIZE(CS), .TOTAL_COLUNES(TC),
    .DIVIDER(DIV), .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .display_data(display_data),
    .row_out(row_out), .colune_sel(colune_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_image();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic predict_position(input int n, input logic [DW-1:0] img);
    int p, k, c;
    logic [DW-1:0] sh;
    p = n % FRAME;
    k = p / DIV;
    c = p % DIV;
    exp_row = '0;
    exp_sel = '1;
    if (c >= BLK) begin
      sh = img >> (CS * k);
      exp_row = sh[CS-1:0];
      exp_sel = ~(TC'(1) << k);
    end
  endtask

  task automatic checkOutput();
    checks++;
    assert (row_out === exp_row) else begin
      errors++;
      $error("[TB] FAIL row_out n=%0d obs=%h exp=%h", m_n, row_out, exp_row);
    end
    checks++;
    assert (colune_sel === exp_sel) else begin
      errors++;
      $error("[TB] FAIL colune_sel n=%0d obs=%b exp=%b", m_n, colune_sel, exp_sel);
    end
    checks++;
    assert (frame_done === exp_done) else begin
      errors++;
      $error("[TB] FAIL frame_done n=%0d obs=%b exp=%b", m_n, frame_done, exp_done);
    end
    checks++;
    assert ($countones(~colune_sel) <= 1) else begin
      errors++;
      $error("[TB] FAIL sel_onehot obs=%b exp=at_most_one_zero", colune_sel);
    end
    checks++;
    assert ((colune_sel !== '1) || (row_out === '0)) else begin
      errors++;
      $error("[TB] FAIL dark_rows obs=%h exp=0", row_out);
    end
  endtask

  // One clock: drive inputs, advance the model with what the edge samples, then compare.
  task automatic applyStimulus(input logic rst, input logic en, input logic [DW-1:0] data);
    reset = rst;
    enable = en;
    display_data = data;
    @(posedge clk);
    #1;
    exp_row = '0;
    exp_sel = '1;
    exp_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_n = 0;
        m_img = data;
      end
    end else begin
      predict_position(m_n, m_img);
      if (!en) begin
        m_active = 1'b0;
      end else begin
        if ((m_n % FRAME) == FRAME - 1) begin
          exp_done = 1'b1;
          m_img = data;
        end
        m_n++;
      end
    end
    checkOutput();
  endtask

  task automatic runCycles(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b1, cur_data);
  endtask

  // Advance while scanning until the next edge lands on column k, slot cycle c.
  task automatic runUntil(input int k, input int c);
    int guard;
    guard = 0;
    while (m_active && ((m_n % FRAME) != k * DIV + c) && guard < 2 * FRAME) begin
      applyStimulus(1'b0, 1'b1, cur_data);
      guard++;
    end
    checks++;
    assert (m_active && guard < 2 * FRAME) else begin
      errors++;
      $error("[TB] FAIL run_until obs=%0d exp=<%0d", guard, 2 * FRAME);
    end
  endtask

  initial begin
    $display("[TB] start");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);

    cur_data = 35'h7_FFFF_FFFF;
    applyStimulus(1'b0, 1'b1, cur_data);
    runCycles(20);
    cur_data = {7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
    runCycles(20 + 2 * FRAME);

    runUntil(2, 4);
    cur_data = rand_image();
    runCycles(FRAME + 10);

    runUntil(3, 5);
    cur_data = rand_image();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, cur_data);
    applyStimulus(1'b0, 1'b1, cur_data);
    cur_data = rand_image();
    runCycles(FRAME + 5);

    runUntil(1, 5);
    applyStimulus(1'b1, 1'b1, cur_data);
    applyStimulus(1'b1, 1'b1, cur_data);
    cur_data = rand_image();
    applyStimulus(1'b0, 1'b1, cur_data);
    runCycles(FRAME + 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
